multicycle_controller: RTL and testbench

Finite-state controller that sequences the shared multi-cycle MIPS datapath: one memory, one ALU, IR, and PC shared across cycles. Takes the opcode from the instruction register and a memory ready handshake. Drives every datapath select and write enable, one state per cycle. Sits beside the register file and ALU control, and replaces the single-cycle opcode decoder in the multi-cycle core.

---
 rtl/mc_pkg.sv | 71 +++++++
 rtl/multicycle_controller_if.sv | 41 ++++
 rtl/mc_output_decode.sv | 90 +++++++++
 rtl/multicycle_controller.sv | 89 ++++++++
 tb/tb_multicycle_controller.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// ============================================================================
// mc_pkg : state, opcode and datapath-select encodings for the multi-cycle
//          MIPS controller.  Rev 1.0
// ============================================================================
`default_nettype none

package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    S_TRAP      = 4'd12
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_AND   = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       bne;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_if.sv
// ============================================================================
// multicycle_controller_if : opcode/handshake inputs and datapath controls
//                            between the controller and the datapath. Rev 1.0
// ============================================================================
`default_nettype none

interface multicycle_controller_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       bne;
  logic       ior_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, bne, ior_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, bne, ior_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op
  );
endinterface

`default_nettype wire

// File: rtl/mc_output_decode.sv
// ============================================================================
// mc_output_decode : combinational map from controller state (plus opcode and
//                    mem_ready for the few Mealy terms) to datapath controls.
//                    Rev 1.0
// ============================================================================
`default_nettype none

module mc_output_decode
  import mc_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR load and PC+4 only commit once memory returns the word
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SL2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.bne           = (opcode == OP_BNE);
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP: begin
        ctrl.illegal_op = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// multicycle_controller : state register and next-state logic sequencing the
//                         shared multi-cycle MIPS datapath.
//                         Optional macro: MC_ILLEGAL_TRAP_EN (sticky trap on
//                         undefined opcodes).  Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_controller
  import mc_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  multicycle_controller_if.master         bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  ctrl_t  ctrl_gated;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_RTYPE:         state_d = S_R_EXEC;
          OP_ADDI, OP_ANDI: state_d = S_I_EXEC;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
          default:          state_d = S_TRAP;
`else
          default:          state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_I_EXEC:    state_d = S_I_WB;
      S_I_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP:      state_d = S_TRAP;
`endif
      default:     state_d = S_FETCH;
    endcase
  end

  mc_output_decode u_output_decode (
    .state     (state_q),
    .opcode    (bus.opcode),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  // Reset must also kill the Moore FETCH outputs, not just park the state
  assign ctrl_gated = rst_n ? ctrl : '0;

  assign bus.pc_write      = ctrl_gated.pc_write;
  assign bus.pc_write_cond = ctrl_gated.pc_write_cond;
  assign bus.bne           = ctrl_gated.bne;
  assign bus.ior_d         = ctrl_gated.ior_d;
  assign bus.mem_read      = ctrl_gated.mem_read;
  assign bus.mem_write     = ctrl_gated.mem_write;
  assign bus.ir_write      = ctrl_gated.ir_write;
  assign bus.mem_to_reg    = ctrl_gated.mem_to_reg;
  assign bus.reg_dst       = ctrl_gated.reg_dst;
  assign bus.reg_write     = ctrl_gated.reg_write;
  assign bus.alu_src_a     = ctrl_gated.alu_src_a;
  assign bus.alu_src_b     = ctrl_gated.alu_src_b;
  assign bus.alu_op        = ctrl_gated.alu_op;
  assign bus.pc_source     = ctrl_gated.pc_source;
  assign bus.illegal_op    = ctrl_gated.illegal_op;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// tb_multicycle_controller : directed instruction sequences expanded into
//                            expected per-cycle control words.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [17:0] w;
  } cyc_t;

  logic [17:0] exp_w;
  logic        exp_valid;

  // word order: pc_write pc_write_cond bne ior_d mem_read mem_write ir_write
  //             mem_to_reg reg_dst reg_write alu_src_a alu_src_b alu_op
  //             pc_source illegal_op
  function automatic logic [17:0] cw(
      input logic pcw, pcwc, bn, iord, mr, mw, irw, m2r, rd, rw, asa,
      input logic [1:0] asb, aop, pcs, input logic ill);
    return {pcw, pcwc, bn, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, ill};
  endfunction

  function automatic logic [17:0] act_word();
    return {bus.pc_write, bus.pc_write_cond, bus.bne, bus.ior_d, bus.mem_read,
            bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
            bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.pc_source, bus.illegal_op};
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b at %0t", name, act, req, $time);
    end
  endtask

  // Single compare point for every scheduled cycle
  always @(negedge clk) begin
    if (exp_valid) begin
      check("ctrl_word", act_word(), exp_w);
      check("we_overlap",
            {16'd0, bus.mem_write & bus.reg_write, bus.pc_write & bus.pc_write_cond},
            18'd0);
    end
  end

  // Expand one instruction into its expected cycles straight from the
  // instruction-class rules, then drive it; stops after 'limit' cycles.
  task automatic exec(input logic [5:0] op, input int fetch_wait,
                      input int mem_wait, input int limit, output int n);
    cyc_t q[$];
    logic [17:0] w_fetch_wait, w_fetch_go;
    w_fetch_wait = cw(0,0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
    w_fetch_go   = cw(1,0,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
    for (int i = 0; i < fetch_wait; i++) q.push_back('{1'b0, w_fetch_wait});
    q.push_back('{1'b1, w_fetch_go});
    q.push_back('{1'b1, cw(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0)});
    case (op)
      6'b100011: begin
        q.push_back('{1'b1, cw(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0)});
        for (int i = 0; i < mem_wait; i++)
          q.push_back('{1'b0, cw(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0)});
        q.push_back('{1'b1, cw(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0)});
        q.push_back('{1'b1, cw(0,0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0)});
      end
      6'b101011: begin
        q.push_back('{1'b1, cw(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0)});
        for (int i = 0; i < mem_wait; i++)
          q.push_back('{1'b0, cw(0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0)});
        q.push_back('{1'b1, cw(0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0)});
      end
      6'b000000: begin
        q.push_back('{1'b1, cw(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0)});
        q.push_back('{1'b1, cw(0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0)});
      end
      6'b001000, 6'b001100: begin
        q.push_back('{1'b1, cw(0,0,0,0,0,0,0,0,0,0,1,2'b10,
                               (op == 6'b001100) ? 2'b11 : 2'b00,2'b00,0)});
        q.push_back('{1'b1, cw(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0)});
      end
      6'b000100, 6'b000101:
        q.push_back('{1'b1, cw(0,1,(op == 6'b000101),0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0)});
      6'b000010:
        q.push_back('{1'b1, cw(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0)});
      default: begin
`ifdef MC_ILLEGAL_TRAP_EN
        // stuck regardless of mem_ready activity
        for (int i = 0; i < 4; i++)
          q.push_back('{logic'(i[0]), cw(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1)});
`endif
      end
    endcase
    n = q.size();
    for (int i = 0; i < q.size() && i < limit; i++) begin
      bus.mem_ready = q[i].rdy;
      bus.opcode    = op;
      exp_w         = q[i].w;
      exp_valid     = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pin_len(input string name, input int act, input int req);
    check(name, 18'(act), 18'(req));
  endtask

  task automatic reset_pulse();
    exp_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("in_reset_outputs", act_word(), 18'd0);
    check("in_reset_illegal", {17'd0, bus.illegal_op}, 18'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int n;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_valid = 1'b0;
    exp_w     = '0;
    rst_n     = 1'b0;
    bus.opcode    = 6'b0;
    bus.mem_ready = 1'b1;
    #2;
    check("reset_outputs", act_word(), 18'd0);
    check("model_fetch_word",
          cw(1,0,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), 18'b100010100000100000);
    @(posedge clk);
    #1;
    check("reset_edge_outputs", act_word(), 18'd0);
    rst_n = 1'b1;

    exec(6'b100011, 0, 0, 99, n); pin_len("len_lw", n, 5);
    exec(6'b101011, 0, 3, 99, n); pin_len("len_sw_wait3", n, 7);
    exec(6'b101011, 0, 0, 99, n); pin_len("len_sw", n, 4);
    exec(6'b000101, 0, 0, 99, n); pin_len("len_bne", n, 3);
    exec(6'b000100, 0, 0, 99, n); pin_len("len_beq", n, 3);
    exec(6'b001000, 2, 0, 99, n); pin_len("len_addi_fwait2", n, 6);
    exec(6'b001100, 0, 0, 99, n); pin_len("len_andi", n, 4);
    exec(6'b000010, 0, 0, 99, n); pin_len("len_j", n, 3);
    exec(6'b100011, 1, 2, 99, n); pin_len("len_lw_waits", n, 8);
    exec(6'b000000, 0, 0, 99, n); pin_len("len_rtype", n, 4);

    // abort an add in its writeback cycle
    exec(6'b000000, 0, 0, 3, n);
    check("rwb_reg_write", {17'd0, bus.reg_write}, 18'd1);
    exp_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("abort_outputs", act_word(), 18'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exec(6'b001000, 0, 0, 99, n);

    exec(6'b111111, 0, 0, 99, n);
`ifdef MC_ILLEGAL_TRAP_EN
    pin_len("len_illegal_trap", n, 6);
    reset_pulse();
`else
    pin_len("len_illegal_nop", n, 2);
`endif
    exec(6'b000101, 0, 0, 99, n);
    exp_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
